// File: rtl/code_serializer_if.sv
// Purpose : bundle of the codeword handshake and serial-line status signals
//           between the codifier-side controller and the code_serializer.
// Signals : code  [4:0] codeword, code[4]=m1 .. code[0]=m5
//           ready       codeword valid, sampled only while idle
//           tx          serial line, idles high
//           busy        frame in progress
//           ack         one-cycle pulse, codeword captured
//           done        one-cycle pulse, stop bit completed
// Modports: master drives code/ready, slave (serializer) drives the rest.
interface code_serializer_if;
   logic [4:0] code;
   logic       ready;
   logic       tx;
   logic       busy;
   logic       ack;
   logic       done;

   modport master (
      output code, ready,
      input  tx, busy, ack, done
   );

   modport slave (
      input  code, ready,
      output tx, busy, ack, done
   );
endinterface

// File: rtl/code_serializer.sv
// Purpose : captures a 5-bit codeword and sends it on a single wire as
//           start(0), m1..m5, even parity, stop(1), each bit BIT_TICKS cycles.
// Ports   : clk    system clock, rising edge
//           reset  asynchronous active-low reset
//           bus    code_serializer_if.slave (code, ready in; tx, busy, ack, done out)
// Params  : BIT_TICKS  clock cycles per serial bit, 1..255
module code_serializer #(
   parameter int unsigned BIT_TICKS = 4
) (
   input logic              clk,
   input logic              reset,
   code_serializer_if.slave bus
);

   localparam int unsigned TICK_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
   localparam int unsigned DATA_W = 5;
   localparam int unsigned IDX_W  = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e              state_q, state_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [IDX_W-1:0]    bit_q, bit_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                par_q, par_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic                ack_q, ack_d;
   logic                done_q, done_d;
   logic                last_tick;

   // Bit boundary: the current bit has been held BIT_TICKS cycles.
   assign last_tick = (tick_q == TICK_W'(BIT_TICKS - 1));

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-output logic; outputs are computed one edge ahead
   // so the registered tx lines up with the frame state.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      ack_d   = 1'b0;
      done_d  = 1'b0;

      if (state_q != S_IDLE) begin
         tick_d = last_tick ? '0 : tick_q + TICK_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            tick_d = '0;
            bit_d  = '0;
            if (bus.ready) begin
               state_d = S_START;
               shift_d = bus.code;
               par_d   = ^bus.code;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               ack_d   = 1'b1;
            end
         end
         S_START: begin
            if (last_tick) begin
               state_d = S_DATA;
               bit_d   = '0;
               tx_d    = shift_q[DATA_W-1];
            end
         end
         S_DATA: begin
            if (last_tick) begin
               if (bit_q == IDX_W'(DATA_W - 1)) begin
                  state_d = S_PARITY;
                  tx_d    = par_q;
               end else begin
                  // Next data bit is the one just below the current MSB.
                  shift_d = {shift_q[DATA_W-2:0], 1'b0};
                  bit_d   = bit_q + IDX_W'(1);
                  tx_d    = shift_q[DATA_W-2];
               end
            end
         end
         S_PARITY: begin
            if (last_tick) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            if (last_tick) begin
               state_d = S_IDLE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.tx   = tx_q;
   assign bus.busy = busy_q;
   assign bus.ack  = ack_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_code_serializer.sv
// Purpose : self-checking bench for code_serializer; one instance with
//           BIT_TICKS=4 and one with BIT_TICKS=1 share the same stimulus and
//           are both checked every cycle against a frame-offset model.
module tb_code_serializer;

   logic       clk;
   logic       reset;
   logic [4:0] code;
   logic       ready;

   int checks   = 0;
   int failures = 0;
   bit run_cmp  = 1'b0;

   code_serializer_if if4 ();
   code_serializer_if if1 ();

   assign if4.code  = code;
   assign if4.ready = ready;
   assign if1.code  = code;
   assign if1.ready = ready;

   code_serializer #(.BIT_TICKS(4)) u_dut4 (.clk(clk), .reset(reset), .bus(if4));
   code_serializer #(.BIT_TICKS(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: off = cycles elapsed since the accepting edge, -1 when idle.
   typedef struct {
      int         off;
      logic [4:0] word;
      logic       ack;
      logic       done;
   } model_t;

   model_t m4 = '{off: -1, word: 5'd0, ack: 1'b0, done: 1'b0};
   model_t m1 = '{off: -1, word: 5'd0, ack: 1'b0, done: 1'b0};

   function automatic model_t step(model_t m, logic rst_n, logic rdy, logic [4:0] c, int bt);
      model_t n = m;
      n.ack  = 1'b0;
      n.done = 1'b0;
      if (!rst_n) begin
         n.off = -1;
      end else if (m.off < 0) begin
         if (rdy) begin
            n.off  = 0;
            n.word = c;
            n.ack  = 1'b1;
         end
      end else begin
         n.off = m.off + 1;
         if (n.off == 8 * bt) begin
            n.off  = -1;
            n.done = 1'b1;
         end
      end
      return n;
   endfunction

   // Frame slot 0 start, 1..5 m1..m5, 6 even parity, 7 stop.
   function automatic logic exp_tx(model_t m, int bt);
      int slot;
      if (m.off < 0) return 1'b1;
      slot = m.off / bt;
      if (slot == 0) return 1'b0;
      if (slot <= 5) return m.word[5 - slot];
      if (slot == 6) return ^m.word;
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      m4 = step(m4, reset, ready, code, 4);
      m1 = step(m1, reset, ready, code, 1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_dut(input string nm, input model_t m, input int bt,
                          input logic tx, input logic busy, input logic ack, input logic done);
      logic etx, ebusy, eack, edone;
      if (!reset) begin
         etx = 1'b1; ebusy = 1'b0; eack = 1'b0; edone = 1'b0;
      end else begin
         etx   = exp_tx(m, bt);
         ebusy = (m.off >= 0);
         eack  = m.ack;
         edone = m.done;
      end
      chk({nm, "_tx"},   32'(tx),   32'(etx));
      chk({nm, "_busy"}, 32'(busy), 32'(ebusy));
      chk({nm, "_ack"},  32'(ack),  32'(eack));
      chk({nm, "_done"}, 32'(done), 32'(edone));
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (run_cmp) begin
         cmp_dut("bt4", m4, 4, if4.tx, if4.busy, if4.ack, if4.done);
         cmp_dut("bt1", m1, 1, if1.tx, if1.busy, if1.ack, if1.done);
      end
   end

   // Starting just after the accepting edge: sample each bit mid-cell,
   // count busy/ack cycles, then check the done cycle.
   task automatic check_capture(input int sel, input int bt, input logic [7:0] exp_seq,
                                input string nm);
      logic [7:0] seq = '0;
      int busy_n = 0;
      int ack_n  = 0;
      for (int k = 0; k < 8 * bt; k++) begin
         @(negedge clk);
         if (k % bt == bt / 2) seq[7 - k / bt] = sel ? if1.tx : if4.tx;
         busy_n += int'(sel ? if1.busy : if4.busy);
         ack_n  += int'(sel ? if1.ack : if4.ack);
      end
      chk({nm, "_seq"},  32'(seq),    32'(exp_seq));
      chk({nm, "_busy_cycles"}, 32'(busy_n), 32'(8 * bt));
      chk({nm, "_ack_count"},   32'(ack_n),  32'd1);
      @(negedge clk);
      chk({nm, "_done"},      32'(sel ? if1.done : if4.done), 32'd1);
      chk({nm, "_busy_end"},  32'(sel ? if1.busy : if4.busy), 32'd0);
   endtask

   task automatic run_frame(input int sel, input int bt, input logic [4:0] c,
                            input logic [7:0] exp_seq, input string nm);
      @(posedge clk); #2;
      code  = c;
      ready = 1'b1;
      @(posedge clk); #2;
      ready = 1'b0;
      code  = ~c;
      check_capture(sel, bt, exp_seq, nm);
   endtask

   initial begin
      reset = 1'b0;
      code  = 5'b11111;
      ready = 1'b1;
      run_cmp = 1'b1;

      // Reset held with ready asserted: outputs stay idle.
      repeat (4) @(negedge clk);
      chk("rst_tx",   32'(if4.tx),   32'd1);
      chk("rst_busy", 32'(if4.busy), 32'd0);
      chk("rst_ack",  32'(if4.ack),  32'd0);

      // Release: accepted at the first edge; all-ones frame, parity 1.
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #2;
      ready = 1'b0;
      code  = 5'b00000;
      check_capture(0, 4, 8'b01111111, "all_ones");

      run_frame(0, 4, 5'b10110, 8'b01011011, "basic");
      run_frame(0, 4, 5'b00000, 8'b00000001, "zeros");

      // Back-to-back with ready held: second frame starts right after done.
      @(posedge clk); #2;
      code  = 5'b01001;
      ready = 1'b1;
      @(posedge clk); #2;
      code  = 5'b10000;
      check_capture(0, 4, 8'b00100101, "b2b_first");
      @(posedge clk); #2;
      ready = 1'b0;
      check_capture(0, 4, 8'b01000011, "b2b_second");

      // Reset during m3 of 01110: line returns high at once, no done.
      repeat (12) @(negedge clk);
      @(posedge clk); #2;
      code  = 5'b01110;
      ready = 1'b1;
      @(posedge clk); #2;
      ready = 1'b0;
      repeat (14) @(negedge clk);
      chk("mid_tx_m3", 32'(if4.tx), 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("mid_rst_tx",   32'(if4.tx),   32'd1);
      chk("mid_rst_busy", 32'(if4.busy), 32'd0);
      repeat (3) @(negedge clk);
      chk("mid_rst_done", 32'(if4.done), 32'd0);
      @(posedge clk); #2;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("after_rst_idle_busy", 32'(if4.busy), 32'd0);
      run_frame(0, 4, 5'b00011, 8'b00001101, "after_rst");

      // One cycle per bit.
      run_frame(1, 1, 5'b10101, 8'b01010111, "bt1");

      repeat (4) @(negedge clk);
      run_cmp = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
